// File: rtl/if_id_buffer_pkg.sv
// Shared pipeline constants and types for the fetch-to-decode boundary.
// Imported by the IF/ID buffer and its performance counters.
package if_id_buffer_pkg;

   localparam int XLEN          = 32;
   localparam int DEFAULT_DEPTH = 2;
   localparam int DEFAULT_CNT_W = 16;

   typedef logic [XLEN-1:0] word_t;

   // addi x0,x0,0 -- what decode sees whenever nothing valid is presented
   localparam word_t NOP_INSTR = 32'h00000013;

   typedef struct packed {
      word_t instrucao;
      word_t pc;
      word_t pc_mais_1;
   } fetch_entry_t;

endpackage

// File: rtl/if_id_buffer_saturating_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
// The clear on synchronous reset is the only way back to zero.
module saturating_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] value
);

   localparam logic [W-1:0] MAX_VAL = '1;

   logic [W-1:0] value_q;
   logic [W-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (inc && (value_q != MAX_VAL)) begin
         value_d = value_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID skid buffer: small in-order FIFO between fetch and decode with
// flush on taken branch/jump and saturating stall/flush counters.
module if_id_buffer
   import if_id_buffer_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_instrucao,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_pc_mais_1,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_instrucao,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_pc_mais_1,
   output logic [CNT_W-1:0] cnt_stall,
   output logic [CNT_W-1:0] cnt_flush
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   // Handshake: a transfer happens on an edge where valid and ready are both
   // high and flush is low. Both ready/valid outputs come from registers only.
   logic push;
   logic pop;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q,  count_d;
   fetch_entry_t     head;

   assign in_ready  = (count_q != FULL_CNT);
   assign out_valid = (count_q != '0);

   assign push = in_valid  & in_ready  & ~flush;
   assign pop  = out_valid & out_ready & ~flush;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is never cleared; empty-state masking below hides stale words.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem_q[wr_ptr_q] <= '{instrucao: in_instrucao, pc: in_pc, pc_mais_1: in_pc_mais_1};
      end
   end

   assign head          = mem_q[rd_ptr_q];
   assign out_instrucao = out_valid ? head.instrucao : NOP_INSTR;
   assign out_pc        = out_valid ? head.pc        : '0;
   assign out_pc_mais_1 = out_valid ? head.pc_mais_1 : '0;

   saturating_counter #(.W(CNT_W)) u_cnt_stall (
      .clk   (clk),
      .reset (reset),
      .inc   (out_valid & ~out_ready & ~flush),
      .value (cnt_stall)
   );

   saturating_counter #(.W(CNT_W)) u_cnt_flush (
      .clk   (clk),
      .reset (reset),
      .inc   (flush),
      .value (cnt_flush)
   );

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for the IF/ID buffer: streaming, stall/back-pressure,
// flush, reset dominance, and counter saturation on a narrow-counter copy.
module tb_if_id_buffer;

   logic        clk = 1'b0;
   logic        reset, in_valid, flush, out_ready;
   logic [31:0] in_instrucao, in_pc, in_pc_mais_1;
   logic        in_ready, out_valid;
   logic [31:0] out_instrucao, out_pc, out_pc_mais_1;
   logic [15:0] cnt_stall, cnt_flush;

   logic        reset2, in_valid2, out_ready2;
   logic        in_ready2, out_valid2;
   logic [31:0] out_instrucao2, out_pc2, out_pc_mais_12;
   logic [3:0]  cnt_stall2, cnt_flush2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   if_id_buffer dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_instrucao(in_instrucao), .in_pc(in_pc), .in_pc_mais_1(in_pc_mais_1),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_instrucao(out_instrucao), .out_pc(out_pc), .out_pc_mais_1(out_pc_mais_1),
      .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
   );

   if_id_buffer #(.DEPTH(2), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset2), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_instrucao(32'h00A00113), .in_pc(32'h00000080), .in_pc_mais_1(32'h00000081),
      .flush(1'b0), .out_valid(out_valid2), .out_ready(out_ready2),
      .out_instrucao(out_instrucao2), .out_pc(out_pc2), .out_pc_mais_1(out_pc_mais_12),
      .cnt_stall(cnt_stall2), .cnt_flush(cnt_flush2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
      in_valid     = v;
      in_pc        = pc;
      in_pc_mais_1 = pc + 32'd1;
      in_instrucao = instr;
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_instr"}, out_instrucao, 32'h00000013);
      check({tag, "_pc"}, out_pc, 32'd0);
      check({tag, "_pc1"}, out_pc_mais_1, 32'd0);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      reset2 = 1'b1; in_valid2 = 1'b0; out_ready2 = 1'b0;
      drive(1'b0, 32'd0, 32'd0);
      #1;
      step(); step();
      reset = 1'b0;
      step();
      check_empty("rst");
      check("rst_cnt_stall", 32'(cnt_stall), 32'd0);
      check("rst_cnt_flush", 32'(cnt_flush), 32'd0);

      // Streaming: one push and one pop per edge, occupancy stays at 1
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h10 + 32'(i), 32'h00500093 + 32'(i << 20));
         step();
         check($sformatf("strm%0d_valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("strm%0d_ready", i), {31'd0, in_ready}, 32'd1);
         check($sformatf("strm%0d_pc", i), out_pc, 32'h10 + 32'(i));
         check($sformatf("strm%0d_pc1", i), out_pc_mais_1, 32'h11 + 32'(i));
         check($sformatf("strm%0d_instr", i), out_instrucao, 32'h00500093 + 32'(i << 20));
      end
      drive(1'b0, 32'd0, 32'd0);
      step();
      check_empty("drain");
      check("strm_cnt_stall", 32'(cnt_stall), 32'd0);

      // Back-pressure: decode stalls while fetch offers 0x10..0x12
      out_ready = 1'b0;
      drive(1'b1, 32'h10, 32'h11111111);
      step();
      check("st1_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 32'h11, 32'h22222222);
      step();
      check("st2_ready", {31'd0, in_ready}, 32'd0);
      check("st2_cnt_stall", 32'(cnt_stall), 32'd1);
      drive(1'b1, 32'h12, 32'h33333333);
      step();
      step();
      check("st_full_ready", {31'd0, in_ready}, 32'd0);
      check("st_cnt_stall", 32'(cnt_stall), 32'd3);
      check("st_head_pc", out_pc, 32'h10);
      check("st_head_instr", out_instrucao, 32'h11111111);
      // Full with out_ready=1: pop only, the offered word is not taken
      out_ready = 1'b1;
      step();
      check("rel1_pc", out_pc, 32'h11);
      check("rel1_ready", {31'd0, in_ready}, 32'd1);
      check("rel1_cnt_stall", 32'(cnt_stall), 32'd3);
      step();
      check("rel2_pc", out_pc, 32'h12);
      check("rel2_instr", out_instrucao, 32'h33333333);
      drive(1'b0, 32'd0, 32'd0);
      step();
      check_empty("rel_empty");

      // Flush a full buffer while fetch offers a wrong-path word
      out_ready = 1'b0;
      drive(1'b1, 32'h20, 32'hAAAA0001);
      step();
      drive(1'b1, 32'h21, 32'hAAAA0002);
      step();
      check("fl_full_ready", {31'd0, in_ready}, 32'd0);
      check("fl_pre_cnt_stall", 32'(cnt_stall), 32'd4);
      flush = 1'b1;
      drive(1'b1, 32'h30, 32'hBBBB0001);
      step();
      flush = 1'b0;
      check_empty("fl");
      check("fl_cnt_flush", 32'(cnt_flush), 32'd1);
      check("fl_cnt_stall", 32'(cnt_stall), 32'd4);
      out_ready = 1'b1;
      drive(1'b1, 32'h40, 32'hCCCC0001);
      step();
      drive(1'b0, 32'd0, 32'd0);
      check("fl_next_pc", out_pc, 32'h40);
      check("fl_next_instr", out_instrucao, 32'hCCCC0001);
      step();
      check_empty("fl_drain");

      // Flush while empty still counts
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_empty("fle");
      check("fle_cnt_flush", 32'(cnt_flush), 32'd2);

      // Reset together with flush at count=2
      out_ready = 1'b0;
      drive(1'b1, 32'h50, 32'hDDDD0001);
      step();
      drive(1'b1, 32'h51, 32'hDDDD0002);
      step();
      check("rf_cnt_stall", 32'(cnt_stall), 32'd5);
      check("rf_full_ready", {31'd0, in_ready}, 32'd0);
      reset = 1'b1; flush = 1'b1;
      step();
      reset = 1'b0; flush = 1'b0;
      drive(1'b0, 32'd0, 32'd0);
      check_empty("rf");
      check("rf_cnt_stall0", 32'(cnt_stall), 32'd0);
      check("rf_cnt_flush0", 32'(cnt_flush), 32'd0);

      // Narrow-counter copy: one word held under stall for 20 edges
      reset2 = 1'b0;
      in_valid2 = 1'b1;
      step();
      in_valid2 = 1'b0;
      check("sat_valid", {31'd0, out_valid2}, 32'd1);
      check("sat_pc", out_pc2, 32'h80);
      for (int i = 0; i < 14; i++) step();
      check("sat_cnt14", 32'(cnt_stall2), 32'd14);
      for (int i = 0; i < 6; i++) step();
      check("sat_cnt15", 32'(cnt_stall2), 32'd15);
      check("sat_cnt_flush", 32'(cnt_flush2), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
